// File: rtl/ibex_rf_write_arbiter.sv
// Register-file write-port arbiter: writeback has fixed priority, LSU and debug share round-robin.
// Also sequences a clear of x1..x31, during which all requesters are stalled.
module ibex_rf_write_arbiter #(
  parameter int unsigned            DataWidth = 32,
  parameter logic [DataWidth-1:0]   ClearVal  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,

  input  logic                 wb_req_i,
  input  logic [4:0]           wb_addr_i,
  input  logic [DataWidth-1:0] wb_data_i,
  output logic                 wb_gnt_o,

  input  logic                 lsu_req_i,
  input  logic [4:0]           lsu_addr_i,
  input  logic [DataWidth-1:0] lsu_data_i,
  output logic                 lsu_gnt_o,

  input  logic                 dbg_req_i,
  input  logic [4:0]           dbg_addr_i,
  input  logic [DataWidth-1:0] dbg_data_i,
  output logic                 dbg_gnt_o,

  input  logic                 clear_req_i,
  output logic                 clear_busy_o,
  output logic                 clear_done_o,

  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o
);

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e     state_q;
  logic [4:0] cnt_q;
  logic       rr_q;
  logic       clear_busy_q;
  logic       clear_done_q;

  logic       idle;
  logic       lsu_wins;
  logic       wb_gnt;
  logic       lsu_gnt;
  logic       dbg_gnt;

  // Grants are masked while reset is asserted, even though the state already reads idle.
  assign idle     = rst_ni && (state_q == StIdle);
  assign lsu_wins = lsu_req_i && (!dbg_req_i || !rr_q);
  assign wb_gnt   = idle && wb_req_i;
  assign lsu_gnt  = idle && !wb_req_i && lsu_wins;
  assign dbg_gnt  = idle && !wb_req_i && dbg_req_i && !lsu_wins;

  assign wb_gnt_o     = wb_gnt;
  assign lsu_gnt_o    = lsu_gnt;
  assign dbg_gnt_o    = dbg_gnt;
  assign clear_busy_o = clear_busy_q;
  assign clear_done_o = clear_done_q;

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (state_q == StClear) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = cnt_q;
      rf_wdata_o = ClearVal;
    end else if (wb_gnt) begin
      rf_waddr_o = wb_addr_i;
      rf_wdata_o = wb_data_i;
      rf_we_o    = (wb_addr_i != 5'd0);
    end else if (lsu_gnt) begin
      rf_waddr_o = lsu_addr_i;
      rf_wdata_o = lsu_data_i;
      rf_we_o    = (lsu_addr_i != 5'd0);
    end else if (dbg_gnt) begin
      rf_waddr_o = dbg_addr_i;
      rf_wdata_o = dbg_data_i;
      rf_we_o    = (dbg_addr_i != 5'd0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= 5'd0;
      rr_q         <= 1'b0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (clear_req_i) begin
            state_q      <= StClear;
            cnt_q        <= 5'd1;
            clear_busy_q <= 1'b1;
          end
          // Point away from the last LSU/debug winner.
          if (lsu_gnt) begin
            rr_q <= 1'b1;
          end else if (dbg_gnt) begin
            rr_q <= 1'b0;
          end
        end
        StClear: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q      <= StDone;
            clear_done_q <= 1'b1;
          end
        end
        StDone: begin
          state_q      <= StIdle;
          clear_done_q <= 1'b0;
          clear_busy_q <= 1'b0;
        end
        default: begin
          state_q      <= StIdle;
          clear_done_q <= 1'b0;
          clear_busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ibex_rf_write_arbiter.md
IBEX_RF_WRITE_ARBITER -- requirements
Module: ibex_rf_write_arbiter

Interface
REQ-001 SHALL have parameter DataWidth, default 32, width of write data.
REQ-002 SHALL have parameter ClearVal, default all-zeros (DataWidth bits), value written by clear sequence.
REQ-003 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports wb_req_i/lsu_req_i/dbg_req_i  input  1 each  write request from writeback, LSU late-load, debug.
REQ-006 SHALL have ports wb_addr_i/lsu_addr_i/dbg_addr_i  input  5 each  destination register.
REQ-007 SHALL have ports wb_data_i/lsu_data_i/dbg_data_i  input  DataWidth each  write data.
REQ-008 SHALL have ports wb_gnt_o/lsu_gnt_o/dbg_gnt_o  output  1 each  grant; request consumed this cycle.
REQ-009 SHALL have port clear_req_i  input  1  start clear of x1..x31.
REQ-010 SHALL have port clear_busy_o  output  1  clear sequence active (CLEAR or DONE state).
REQ-011 SHALL have port clear_done_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports rf_waddr_o  output  5, rf_wdata_o  output  DataWidth, rf_we_o  output  1  register-file write port.

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, DONE; reset state IDLE.
REQ-014 In IDLE, SHALL grant combinationally (zero latency) at most one requester per cycle.
REQ-015 wb SHALL have fixed highest priority; granted whenever wb_req_i=1 in IDLE.
REQ-016 lsu/dbg SHALL be arbitrated round-robin via 1-bit pointer rr_q (0 = lsu preferred), only when wb_req_i=0.
REQ-017 rr_q SHALL toggle to point away from the winner after each lsu or dbg grant; unchanged on wb grants or idle cycles.
REQ-018 Granted requester's addr/data SHALL drive rf_waddr_o/rf_wdata_o in the same cycle; rf_we_o=1 unless addr=0.
REQ-019 Grant to addr 0 SHALL still assert gnt (write dropped, rf_we_o=0).
REQ-020 With no grant, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
REQ-021 Requesters hold req/addr/data stable until gnt; arbiter SHALL NOT buffer requests.
REQ-022 clear_req_i=1 in IDLE SHALL move to CLEAR next cycle with 5-bit counter cnt_q=1; requests granted normally in that IDLE cycle.
REQ-023 In CLEAR, SHALL drive rf_we_o=1, rf_waddr_o=cnt_q, rf_wdata_o=ClearVal; cnt_q increments each cycle.
REQ-024 When cnt_q=31 in CLEAR, SHALL go to DONE next cycle and cnt_q SHALL wrap to 0; exactly 31 write cycles.
REQ-025 In DONE, SHALL assert clear_done_o=1 for one cycle, rf_we_o=0, then return to IDLE.
REQ-026 In CLEAR and DONE, all gnt outputs SHALL be 0; clear_busy_o=1.
REQ-027 clear_req_i in CLEAR or DONE SHALL be ignored (no restart, no queueing).
REQ-028 Register 0 SHALL never be written by the clear sequence.

Reset
REQ-029 On rst_ni=0, SHALL asynchronously set state=IDLE, cnt_q=0, rr_q=0.
REQ-030 During reset, all gnt, rf_we_o, clear_busy_o, clear_done_o SHALL be 0; rf_waddr_o=0, rf_wdata_o=0.
REQ-031 Reset mid-CLEAR SHALL abort immediately; no clear_done_o pulse; after release, IDLE with normal grants.

Verification
REQ-032 wb_req=1 addr 5 data 0xA5A5A5A5 with lsu_req=1 addr 6 -> same cycle wb_gnt=1, rf_we=1, rf_waddr=5, rf_wdata=0xA5A5A5A5; lsu_gnt=0; rr_q unchanged.
REQ-033 lsu and dbg both requesting continuously for 4 cycles from reset, wb idle -> grants lsu, dbg, lsu, dbg.
REQ-034 dbg_req=1 addr 0 data 0x1234 -> dbg_gnt=1, rf_we=0.
REQ-035 clear_req pulse in IDLE -> next 31 cycles rf_we=1, rf_waddr 1..31, rf_wdata=0; then one cycle clear_done=1; clear_busy=1 for 32 cycles; wb_req held throughout granted first cycle after return to IDLE.
REQ-036 rst_ni low at 10th CLEAR cycle (rf_waddr=10) -> outputs 0 immediately, clear_done never pulses, wb_req granted on first cycle after release.
REQ-037 clear_req held high through whole sequence -> single sequence, then new sequence starts from IDLE cycle following DONE.
